// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART: register offsets, STATUS/CTRL bit
// positions, CTRL reset value and the TX/RX state encodings.
package uart_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_RX_FULL     = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_TX_FULL     = 3;
  localparam int ST_FERR        = 4;
  localparam int ST_OVR         = 5;
  localparam int ST_W           = 6;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_IE_RX  = 2;
  localparam int CTRL_IE_TX  = 3;
  localparam int CTRL_IE_ERR = 4;
  localparam int CTRL_W      = 5;

  localparam logic [CTRL_W-1:0] CTRL_RESET = 5'h03;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef struct packed {
    tx_state_t tx;
    rx_state_t rx;
  } uart_dbg_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A push on a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_uart.sv
// APB-attached 8N1 UART: programmable baud divisor, TX/RX FIFOs, sticky
// framing/overrun flags and a registered level interrupt.
module apb_uart
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = 867
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            pstb,
  output logic                  ready,
  output logic                  perr,
  output logic                  txd,
  input  logic                  rxd,
  output logic                  irq
);

  logic [DIV_WIDTH-1:0] div;
  logic [CTRL_W-1:0]    ctrl;
  logic                 ferr, ovr, ferr_set, ovr_set;
  logic [ST_W-1:0]      status;

  logic       tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic [7:0] tx_dout;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_dout;

  tx_state_t            tx_state, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]           tx_bit, tx_bit_d;
  logic [7:0]           tx_sh, tx_sh_d;

  rx_state_t            rx_state, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]           rx_bit, rx_bit_d;
  logic [7:0]           rx_sh, rx_sh_d;
  logic                 rx_meta, rxs, rxs_q, rx_fall, stop_ok, stop_bad;

  // Both state machines, visible to bound checkers
  uart_dbg_t dbg;
  assign dbg = '{tx: tx_state, rx: rx_state};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(pclk), .rst_n(presetn), .push(tx_push), .din(pdata[7:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(pclk), .rst_n(presetn), .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  assign tx_idle = tx_empty && (tx_state == TX_IDLE);
  assign status  = {ovr, ferr, tx_full, tx_idle, rx_full, !rx_empty};

  // Handshake: an access completes on the edge where psel && penable && !ready;
  // ready is then a one-cycle pulse qualifying prdata/perr, both zero otherwise.
  logic                  access, addr_ok, err, wr_status, wr_div, wr_ctrl;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [3:0]            off;
  logic [31:0]           byte_mask;

  assign access    = psel && penable && !ready;
  // Only the 16-byte register window, word aligned, is decoded
  assign addr_ok   = (paddr[1:0] == 2'b00) && (paddr[ADDR_WIDTH-1:4] == '0);
  assign off       = paddr[3:0];
  assign byte_mask = {{8{pstb[3]}}, {8{pstb[2]}}, {8{pstb[1]}}, {8{pstb[0]}}};

  always_comb begin
    rd_val    = '0;
    err       = 1'b0;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    wr_status = 1'b0;
    wr_div    = 1'b0;
    wr_ctrl   = 1'b0;
    if (access) begin
      if (!addr_ok) begin
        err = 1'b1;
      end else begin
        case (off)
          OFF_DATA: begin
            if (pwrite) begin
              if (pstb[0]) begin
                if (tx_full) err = 1'b1;
                else         tx_push = 1'b1;
              end
            end else if (rx_empty) begin
              err = 1'b1;
            end else begin
              rx_pop      = 1'b1;
              rd_val[7:0] = rx_dout;
            end
          end
          OFF_STATUS: if (pwrite) wr_status = 1'b1; else rd_val[ST_W-1:0] = status;
          OFF_DIV:    if (pwrite) wr_div = 1'b1;    else rd_val[DIV_WIDTH-1:0] = div;
          OFF_CTRL:   if (pwrite) wr_ctrl = 1'b1;   else rd_val[CTRL_W-1:0] = ctrl;
          default:    err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ready  <= 1'b0;
      prdata <= '0;
      perr   <= 1'b0;
      div    <= DIV_WIDTH'(DIV_RESET);
      ctrl   <= CTRL_RESET;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ready  <= access;
      prdata <= rd_val;
      perr   <= err;
      if (wr_div)
        div <= (div & ~byte_mask[DIV_WIDTH-1:0]) | (pdata[DIV_WIDTH-1:0] & byte_mask[DIV_WIDTH-1:0]);
      if (wr_ctrl && pstb[0]) ctrl <= pdata[CTRL_W-1:0];
      // A flag being set in the same cycle as its clear stays set
      ferr <= ferr_set | (ferr & !(wr_status && pstb[0] && pdata[ST_FERR]));
      ovr  <= ovr_set  | (ovr  & !(wr_status && pstb[0] && pdata[ST_OVR]));
      irq  <= (!rx_empty & ctrl[CTRL_IE_RX]) | (tx_idle & ctrl[CTRL_IE_TX]) |
              ((ferr | ovr) & ctrl[CTRL_IE_ERR]);
    end
  end

  // TX: state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
    end
  end

  // TX: next state; every bit reloads its counter from the live divisor
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    case (tx_state)
      TX_IDLE: begin
        if (ctrl[CTRL_TX_EN] && !tx_empty) begin
          tx_state_d = TX_START;
          tx_cnt_d   = div;
          tx_sh_d    = tx_dout;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = div;
          tx_bit_d   = '0;
        end else tx_cnt_d = tx_cnt - DIV_WIDTH'(1);
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_d = div;
          if (tx_bit == 3'd7) tx_state_d = TX_STOP;
          else begin
            tx_bit_d = tx_bit + 3'd1;
            tx_sh_d  = tx_sh >> 1;
          end
        end else tx_cnt_d = tx_cnt - DIV_WIDTH'(1);
      end
      TX_STOP: begin
        if (tx_cnt == '0) tx_state_d = TX_IDLE;
        else              tx_cnt_d   = tx_cnt - DIV_WIDTH'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX: outputs
  always_comb begin
    tx_pop = 1'b0;
    txd    = 1'b1;
    case (tx_state)
      TX_IDLE:  tx_pop = ctrl[CTRL_TX_EN] && !tx_empty;
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_sh[0];
      default:  txd = 1'b1;
    endcase
  end

  // RX: synchroniser plus state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_q    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rxs_q    <= rxs;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
    end
  end

  assign rx_fall = rxs_q && !rxs;

  // RX: next state; the half-period start wait centres later samples
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    case (rx_state)
      RX_IDLE: begin
        if (ctrl[CTRL_RX_EN] && rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = div >> 1;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (!rxs) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = div;
            rx_bit_d   = '0;
          end else rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt - DIV_WIDTH'(1);
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_sh_d  = {rxs, rx_sh[7:1]};
          rx_cnt_d = div;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
          else                rx_bit_d   = rx_bit + 3'd1;
        end else rx_cnt_d = rx_cnt - DIV_WIDTH'(1);
      end
      RX_STOP: begin
        if (rx_cnt == '0) rx_state_d = RX_IDLE;
        else              rx_cnt_d   = rx_cnt - DIV_WIDTH'(1);
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX: outputs at the stop-bit sample
  always_comb begin
    stop_ok  = (rx_state == RX_STOP) && (rx_cnt == '0) && rxs;
    stop_bad = (rx_state == RX_STOP) && (rx_cnt == '0) && !rxs;
    rx_push  = stop_ok && (!rx_full || rx_pop);
    ovr_set  = stop_ok && rx_full && !rx_pop;
    ferr_set = stop_bad;
  end

  logic unused_ok;
  assign unused_ok = ^{pdata, pstb, byte_mask, dbg};

endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for apb_uart: TX waveform, loopback, RX overrun, framing
// error, glitch rejection, error responses and mid-frame reset.
module tb_apb_uart;

  localparam int DEPTH = 4;
  localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_DIV = 32'h8, A_CTRL = 32'hC;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] paddr, pdata, prdata;
  logic        psel, penable, pwrite, ready, perr, txd, rxd, irq;
  logic [3:0]  pstb;
  logic        rxd_drv, loop;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [31:0] rd;
  logic        er;
  logic        exp_ovr;

  assign rxd = loop ? txd : rxd_drv;

  apb_uart #(.FIFO_DEPTH(DEPTH)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pdata(pdata), .prdata(prdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb), .ready(ready),
    .perr(perr), .txd(txd), .rxd(rxd), .irq(irq)
  );

  // clock / watchdog
  always #5 pclk = ~pclk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_chk);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = wdata; pstb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (ready === 1'b1) break;
    end
    check("apb_ready", {31'b0, ready}, 32'h1);
    rdata = prdata;
    err   = perr;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] wdata, output logic err);
    logic [31:0] d;
    apb_xfer(1'b1, addr, wdata, d, err);
  endtask

  task automatic apb_rd(input logic [31:0] addr, output logic [31:0] rdata, output logic err);
    apb_xfer(1'b0, addr, 32'h0, rdata, err);
  endtask

  task automatic rx_level(input logic lvl);
    rxd_drv = lvl;
    repeat (4) @(negedge pclk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [7:0] s;
    s = b;
    rx_level(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx_level(s[0]);
      s = s >> 1;
    end
    rx_level(stop);
    rxd_drv = 1'b1;
    repeat (6) @(negedge pclk);
  endtask

  // DIV=3: each bit period is 4 samples taken on falling edges
  task automatic check_tx_frame(input logic [7:0] b);
    logic [7:0] s;
    logic [3:0] v;
    logic       lvl;
    s = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (txd === 1'b0) break;
    end
    check("tx_start_seen", {31'b0, txd}, 32'h0);
    for (int p = 0; p < 10; p++) begin
      if (p == 0) lvl = 1'b0;
      else if (p == 9) lvl = 1'b1;
      else begin
        lvl = s[0];
        s = s >> 1;
      end
      v = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (p != 0 || k != 0) @(negedge pclk);
        v = {txd, v[3:1]};
      end
      check($sformatf("tx_period%0d", p), {28'b0, v}, {28'b0, {4{lvl}}});
    end
  endtask

  function automatic logic [31:0] exp_status(input int rx_n, input logic txi, input logic txf,
                                             input logic fe, input logic ov);
    exp_status = {26'b0, ov, fe, txf, txi, (rx_n == DEPTH), (rx_n != 0)};
  endfunction

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pdata = '0; pstb = 4'h0; rxd_drv = 1'b1; loop = 1'b0; exp_ovr = 1'b0;
    repeat (3) @(negedge pclk);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_perr", {31'b0, perr}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_txd", {31'b0, txd}, 32'h1);
    check("rst_irq", {31'b0, irq}, 32'h0);
    presetn = 1'b1;
    @(negedge pclk);
    apb_rd(A_STATUS, rd, er); check("rst_status", rd, 32'h4);
    apb_rd(A_DIV, rd, er);    check("rst_div", rd, 32'd867);
    apb_rd(A_CTRL, rd, er);   check("rst_ctrl", rd, 32'h3);

    // TX waveform of 0x55
    apb_wr(A_DIV, 32'd3, er);
    apb_rd(A_DIV, rd, er); check("div_rw", rd, 32'd3);
    tx_q.push_back(8'h55);
    apb_wr(A_DATA, 32'h55, er); check("tx_wr_perr", {31'b0, er}, 32'h0);
    check_tx_frame(tx_q.pop_front());
    apb_rd(A_STATUS, rd, er); check("tx_idle_after", rd, exp_status(0, 1, 0, 0, 0));

    // loopback of two back-to-back frames
    loop = 1'b1;
    exp_q.push_back(8'hA5); apb_wr(A_DATA, 32'hA5, er);
    exp_q.push_back(8'h3C); apb_wr(A_DATA, 32'h3C, er);
    repeat (100) @(negedge pclk);
    apb_rd(A_STATUS, rd, er); check("loop_status", rd, exp_status(exp_q.size(), 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      apb_rd(A_DATA, rd, er);
      check("loop_data", rd, {24'b0, exp_q.pop_front()});
      check("loop_perr", {31'b0, er}, 32'h0);
    end
    apb_rd(A_DATA, rd, er);
    check("empty_rd_perr", {31'b0, er}, 32'h1);
    check("empty_rd_data", rd, 32'h0);
    loop = 1'b0;

    // RX overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_rx(8'(i * 8'h11), 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i * 8'h11));
      else exp_ovr = 1'b1;
    end
    apb_rd(A_STATUS, rd, er); check("ovr_status", rd, exp_status(exp_q.size(), 1, 0, 0, exp_ovr));
    apb_wr(A_STATUS, 32'h20, er);
    apb_rd(A_STATUS, rd, er); check("ovr_cleared", rd, exp_status(exp_q.size(), 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      apb_rd(A_DATA, rd, er);
      check("ovr_data", rd, {24'b0, exp_q.pop_front()});
    end

    // framing error with ie_err
    apb_wr(A_CTRL, 32'h13, er);
    @(negedge pclk);
    check("irq_quiet", {31'b0, irq}, 32'h0);
    send_rx(8'h5A, 1'b0);
    apb_rd(A_STATUS, rd, er); check("ferr_status", rd, exp_status(0, 1, 0, 1, 0));
    check("ferr_irq", {31'b0, irq}, 32'h1);
    apb_rd(A_DATA, rd, er); check("ferr_discard", {31'b0, er}, 32'h1);
    apb_wr(A_STATUS, 32'h10, er);
    apb_rd(A_STATUS, rd, er); check("ferr_cleared", rd, exp_status(0, 1, 0, 0, 0));
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // single-cycle glitch
    @(negedge pclk); rxd_drv = 1'b0;
    @(negedge pclk); rxd_drv = 1'b1;
    repeat (20) @(negedge pclk);
    apb_rd(A_STATUS, rd, er); check("glitch_status", rd, exp_status(0, 1, 0, 0, 0));

    // error accesses
    send_rx(8'h77, 1'b1); exp_q.push_back(8'h77);
    apb_rd(32'h2, rd, er);
    check("misalign_perr", {31'b0, er}, 32'h1);
    check("misalign_data", rd, 32'h0);
    apb_rd(A_STATUS, rd, er); check("misalign_nopop", rd, exp_status(exp_q.size(), 1, 0, 0, 0));
    apb_wr(32'h10, 32'hFF, er);
    check("oob_perr", {31'b0, er}, 32'h1);
    @(negedge pclk);
    check("ready_pulse", {31'b0, ready}, 32'h0);
    apb_rd(A_STATUS, rd, er); check("oob_nopush", rd, exp_status(exp_q.size(), 1, 0, 0, 0));
    apb_rd(A_DATA, rd, er); check("err_rx_data", rd, {24'b0, exp_q.pop_front()});

    // TX FIFO full
    apb_wr(A_CTRL, 32'h02, er);
    for (int i = 0; i < DEPTH; i++) begin
      tx_q.push_back(8'(8'h10 + i));
      apb_wr(A_DATA, 32'(8'h10 + i), er);
      check("fill_perr", {31'b0, er}, 32'h0);
    end
    apb_rd(A_STATUS, rd, er); check("tx_full_status", rd, exp_status(0, 0, 1, 0, 0));
    apb_wr(A_DATA, 32'hEE, er); check("tx_full_perr", {31'b0, er}, 32'h1);
    @(negedge pclk);
    check("full_ready_pulse", {31'b0, ready}, 32'h0);
    apb_rd(A_STATUS, rd, er); check("tx_full_kept", rd, exp_status(0, 0, 1, 0, 0));
    apb_wr(A_CTRL, 32'h03, er);
    check_tx_frame(tx_q.pop_front());

    // reset in the middle of the next frame (0x11, bit1 low)
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (txd === 1'b0) break;
    end
    repeat (9) @(negedge pclk);
    check("mid_frame_low", {31'b0, txd}, 32'h0);
    #1 presetn = 1'b0;
    #1 check("reset_txd_high", {31'b0, txd}, 32'h1);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    apb_rd(A_STATUS, rd, er); check("post_rst_status", rd, 32'h4);
    apb_rd(A_DIV, rd, er);    check("post_rst_div", rd, 32'd867);
    apb_rd(A_CTRL, rd, er);   check("post_rst_ctrl", rd, 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
